// File: rtl/aemb2_xintu.sv
// aemb2_xintu: integer execution unit with per-thread carry banks and a
// serial restoring divider.
//
// Handshake: an operation is taken on a rising gclk edge when dena=1,
// op_vld=1 and busy=0. Anything else leaves op_vld unacknowledged, and the
// requester keeps it asserted. res_vld marks the one edge on which res
// carries a fresh result. It is never raised on an edge with dena=0.
module aemb2_xintu #(
    parameter int DW  = 32,
    parameter int NTH = 2
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          dena,
    input  logic          gpha,
    input  logic          op_vld,
    input  logic [3:0]    op_sel,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    input  logic          div_uns,
    output logic [DW-1:0] res,
    output logic          res_vld,
    output logic          busy,
    output logic          dbz,
    output logic          msr_c,
    output logic          dbg_state
);

    localparam int CW = $clog2(DW);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_ADDC   = 4'd1;
    localparam logic [3:0] OP_RSUB   = 4'd2;
    localparam logic [3:0] OP_RSUBC  = 4'd3;
    localparam logic [3:0] OP_CMP    = 4'd4;
    localparam logic [3:0] OP_CMPU   = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_AND    = 4'd7;
    localparam logic [3:0] OP_XOR    = 4'd8;
    localparam logic [3:0] OP_ANDN   = 4'd9;
    localparam logic [3:0] OP_SRA    = 4'd10;
    localparam logic [3:0] OP_SRC    = 4'd11;
    localparam logic [3:0] OP_SRL    = 4'd12;
    localparam logic [3:0] OP_SEXT8  = 4'd13;
    localparam logic [3:0] OP_SEXT16 = 4'd14;
    localparam logic [3:0] OP_IDIV   = 4'd15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t state;

    // Two carry flops always exist. With NTH=1 only bit 0 is ever written,
    // so bit 1 stays at its reset value and is trimmed away.
    logic [1:0] carry;
    logic       ctx;
    logic       cin_ctx;
    logic       accept;

    assign ctx       = (NTH == 2) ? gpha : 1'b0;
    assign cin_ctx   = carry[ctx];
    assign msr_c     = cin_ctx;
    assign accept    = dena & op_vld & ~busy;
    assign dbg_state = (state == S_DIV);

    // ALU datapath for the single-cycle operations
    logic [DW:0]   add_sum;
    logic [DW:0]   sub_sum;
    logic          add_cin;
    logic          sub_cin;
    logic [DW-2:0] dif_lo;
    logic [DW-1:0] alu_res;
    logic          alu_wc;
    logic          alu_c;

    // Combinational ALU: result, whether carry is written, and the new carry
    always_comb begin
        add_cin = op_sel[0] ? cin_ctx : 1'b0;
        sub_cin = op_sel[0] ? cin_ctx : 1'b1;
        add_sum = {1'b0, opb} + {1'b0, opa} + {{DW{1'b0}}, add_cin};
        sub_sum = {1'b0, opb} + {1'b0, ~opa} + {{DW{1'b0}}, sub_cin};
        // The compare MSB is replaced, so only the low bits of the difference matter
        dif_lo  = opb[DW-2:0] - opa[DW-2:0];
        alu_res = '0;
        alu_wc  = 1'b0;
        alu_c   = cin_ctx;
        case (op_sel)
            OP_ADD, OP_ADDC: begin
                alu_res = add_sum[DW-1:0];
                alu_wc  = 1'b1;
                alu_c   = add_sum[DW];
            end
            OP_RSUB, OP_RSUBC: begin
                alu_res = sub_sum[DW-1:0];
                alu_wc  = 1'b1;
                alu_c   = sub_sum[DW];
            end
            OP_CMP:    alu_res = {($signed(opa) > $signed(opb)), dif_lo};
            OP_CMPU:   alu_res = {(opa > opb), dif_lo};
            OP_OR:     alu_res = opa | opb;
            OP_AND:    alu_res = opa & opb;
            OP_XOR:    alu_res = opa ^ opb;
            OP_ANDN:   alu_res = opa & ~opb;
            OP_SRA: begin
                alu_res = {opa[DW-1], opa[DW-1:1]};
                alu_wc  = 1'b1;
                alu_c   = opa[0];
            end
            OP_SRC: begin
                alu_res = {cin_ctx, opa[DW-1:1]};
                alu_wc  = 1'b1;
                alu_c   = opa[0];
            end
            OP_SRL: begin
                alu_res = {1'b0, opa[DW-1:1]};
                alu_wc  = 1'b1;
                alu_c   = opa[0];
            end
            OP_SEXT8:  alu_res = DW'($signed(opa[7:0]));
            OP_SEXT16: alu_res = DW'($signed(opa[15:0]));
            default:   alu_res = '0;
        endcase
    end

    // Divider state: remainder, quotient/dividend shift register, divisor
    logic [DW-1:0] div_r;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          div_neg;
    logic [CW-1:0] div_cnt;

    logic          dvd_neg;
    logic          dvs_neg;
    logic [DW-1:0] dvd_mag;
    logic [DW-1:0] dvs_mag;
    logic [DW:0]   div_rr;
    logic [DW:0]   div_sub;
    logic          div_ge;
    logic [DW-1:0] div_r_nxt;
    logic [DW-1:0] div_q_nxt;
    logic [DW-1:0] div_q_fin;

    // Operand magnitudes at issue and one restoring step per enabled cycle
    always_comb begin
        dvd_neg   = ~div_uns & opb[DW-1];
        dvs_neg   = ~div_uns & opa[DW-1];
        // The most-negative value maps to itself, which is its correct unsigned magnitude
        dvd_mag   = dvd_neg ? -opb : opb;
        dvs_mag   = dvs_neg ? -opa : opa;
        div_rr    = {div_r, div_q[DW-1]};
        div_sub   = div_rr - {1'b0, div_d};
        // The remainder stays below the divisor, so a clear top bit means rr >= divisor
        div_ge    = ~div_sub[DW];
        div_r_nxt = div_ge ? div_sub[DW-1:0] : div_rr[DW-1:0];
        div_q_nxt = {div_q[DW-2:0], div_ge};
        div_q_fin = div_neg ? -div_q_nxt : div_q_nxt;
    end

    // Control FSM, result register, flags and carry banks
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            res     <= '0;
            res_vld <= 1'b0;
            dbz     <= 1'b0;
            carry   <= '0;
            div_r   <= '0;
            div_q   <= '0;
            div_d   <= '0;
            div_neg <= 1'b0;
            div_cnt <= '0;
        end else begin
            res_vld <= 1'b0;
            if (dena) begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            if (op_sel == OP_IDIV) begin
                                if (opa == '0) begin
                                    res     <= '0;
                                    res_vld <= 1'b1;
                                    dbz     <= 1'b1;
                                end else begin
                                    state   <= S_DIV;
                                    busy    <= 1'b1;
                                    dbz     <= 1'b0;
                                    div_r   <= '0;
                                    div_q   <= dvd_mag;
                                    div_d   <= dvs_mag;
                                    div_neg <= dvd_neg ^ dvs_neg;
                                    div_cnt <= '0;
                                end
                            end else begin
                                res     <= alu_res;
                                res_vld <= 1'b1;
                                dbz     <= 1'b0;
                                if (alu_wc) begin
                                    carry[ctx] <= alu_c;
                                end
                            end
                        end
                    end
                    S_DIV: begin
                        div_r   <= div_r_nxt;
                        div_q   <= div_q_nxt;
                        div_cnt <= div_cnt + CW'(1);
                        if (div_cnt == CW'(DW - 1)) begin
                            res     <= div_q_fin;
                            res_vld <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/aemb2_xintu.md
AEMB2_XINTU -- requirements
Module: aemb2_xintu

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width in bits, legal values 16..64.
REQ-002 SHALL have parameter NTH, default 2, number of hardware-thread carry contexts, legal values 1 or 2.
REQ-003 SHALL have port gclk, input, 1 bit, single clock; all flops rise-edge triggered.
REQ-004 SHALL have port grst, input, 1 bit, reset: asynchronous assertion, active-low.
REQ-005 SHALL have port dena, input, 1 bit, pipeline enable; when low, all state holds.
REQ-006 SHALL have port gpha, input, 1 bit, thread phase; selects carry context when NTH=2, ignored when NTH=1.
REQ-007 SHALL have port op_vld, input, 1 bit, operation request.
REQ-008 SHALL have port op_sel, input, 4 bits, operation code per REQ-013.
REQ-009 SHALL have ports opa and opb, inputs, DW bits each, operands A and B.
REQ-010 SHALL have port div_uns, input, 1 bit, unsigned divide when 1, signed when 0.
REQ-011 SHALL have port res, output, DW bits, registered result; also port res_vld, output, 1 bit, one-cycle result strobe.
REQ-012 SHALL have port busy, output, 1 bit, divider occupied; port dbz, output, 1 bit, divide-by-zero flag; port msr_c, output, 1 bit, carry of the context selected by gpha.

Function
REQ-013 SHALL decode op_sel as follows: 0 ADD, 1 ADDC, 2 RSUB, 3 RSUBC, 4 CMP, 5 CMPU, 6 OR, 7 AND, 8 XOR, 9 ANDN (a&~b), 10 SRA, 11 SRC, 12 SRL, 13 SEXT8, 14 SEXT16, 15 IDIV.
REQ-014 SHALL accept an operation on a rising edge where dena=1, op_vld=1 and busy=0; all other op_vld are ignored, and the requester holds the request.
REQ-015 SHALL, for ops 0-14, register res and pulse res_vld for one cycle on the accept edge (latency 1).
REQ-016 SHALL compute ADD/ADDC as opb+opa+cin, where cin=0 for ADD and the context carry for ADDC; carry-out = bit DW of the sum.
REQ-017 SHALL compute RSUB/RSUBC as opb+~opa+cin, where cin=1 for RSUB and the context carry for RSUBC; carry = no-borrow.
REQ-018 SHALL make CMP/CMPU return opb-opa with the MSB replaced by (opa>opb), using signed comparison for CMP and unsigned for CMPU; carry unchanged.
REQ-019 SHALL shift right by 1 for SRA/SRC/SRL, filling the MSB with opa[DW-1], the context carry, or 0 respectively; new carry = opa[0].
REQ-020 SHALL sign-extend opa[7:0] for SEXT8 and opa[15:0] for SEXT16 to DW bits; logic and SEXT ops leave carry unchanged.
REQ-021 SHALL keep NTH carry flops; an accepted carry-writing op updates only context gpha (context 0 when NTH=1).
REQ-022 SHALL implement IDIV with FSM states IDLE and DIV, using a restoring algorithm that computes one quotient bit per enabled cycle, with res = opb/opa truncated toward zero.
REQ-023 SHALL, when IDIV is accepted with opa!=0, enter DIV and set busy=1; after exactly DW further dena=1 edges, register the quotient, pulse res_vld, clear busy and return to IDLE.
REQ-024 SHALL, for signed IDIV, divide magnitudes and negate the quotient when the operand signs differ; the most-negative value divided by -1 returns the most-negative value (wrap).
REQ-025 SHALL, when IDIV is accepted with opa=0, set res=0 and dbz=1 with latency 1 and never assert busy; any other accepted op clears dbz.
REQ-026 SHALL freeze the divider counter and partial remainder while dena=0 in DIV; res_vld is low on every edge with dena=0.
REQ-027 SHALL make IDIV leave carry unchanged; msr_c is combinational from the carry banks and gpha.

Reset
REQ-028 SHALL, while grst=0, force res=0, res_vld=0, busy=0, dbz=0, all carries=0 and FSM=IDLE immediately, including mid-division, aborting the division with no res_vld.
REQ-029 SHALL accept the first operation on the first dena=1 edge after grst rises.

Verification
REQ-030 SHALL check: ADD opa=0xFFFFFFFF, opb=1, gpha=0 -> res=0, msr_c=1 for gpha=0, msr_c=0 for gpha=1; then ADDC opa=2, opb=3, gpha=0 -> res=6.
REQ-031 SHALL check: RSUB opa=7, opb=5 -> res=0xFFFFFFFE, carry=0; CMP opa=7, opb=5 -> res[31]=1; CMPU opa=0xFFFFFFFF, opb=1 -> res[31]=1; CMP opa=-1, opb=1 -> res[31]=0.
REQ-032 SHALL check: signed IDIV opb=-7, opa=2 -> busy high for 32 enabled edges, then res=0xFFFFFFFD and a single res_vld pulse; a second op_vld during busy is ignored.
REQ-033 SHALL check: IDIV opa=0 -> next edge res=0, dbz=1, busy=0 throughout; unsigned IDIV 0x80000000/0xFFFFFFFF -> res=0.
REQ-034 SHALL check: dena=0 for 5 cycles mid-division -> completion delayed by exactly 5 cycles with correct quotient; SRC with carry=1, opa=0x2 -> res=0x80000001, carry=0.
REQ-035 SHALL check: grst=0 asserted at division iteration 10 -> busy=0, res=0 and carries=0 without waiting for a clock edge; no res_vld after release.
